// File: rtl/key_cmd_gen.sv
// rtl/key_cmd_gen.sv - debounced push-button to I2C EEPROM command generator
//
// Turns two raw active-low push-buttons into single read/write commands for a
// downstream I2C EEPROM controller using a valid/ready handshake.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        asynchronous active-low reset
//   key_wr_n   raw active-low write button (asynchronous to clk)
//   key_rd_n   raw active-low read button (asynchronous to clk)
//   sw_data    DIP-switch data, captured when a write command is issued
//   cmd_valid  command available downstream
//   cmd_ready  downstream accepts the command
//   cmd_rw     0 = write, 1 = read
//   cmd_data   {4'b0000, captured sw_data}
//   cmd_count  number of accepted commands (wraps at 256)
module key_cmd_gen #(
   parameter int DEBOUNCE_CNT = 800000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_wr_n,
   input  logic       key_rd_n,
   input  logic [3:0] sw_data,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       cmd_rw,
   output logic [7:0] cmd_data,
   output logic [7:0] cmd_count
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] ISSUE    = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CNT - 1);

   logic [1:0]  wr_sync;
   logic [1:0]  rd_sync;
   logic        wr_s;
   logic        rd_s;
   logic [1:0]  state;
   logic [19:0] counter;
   logic        pend_rw;
   logic        pend_low;

   // Synchronizers reset to 1 so a key already held at reset release is seen
   // as a fresh high-to-low press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_sync <= 2'b11;
         rd_sync <= 2'b11;
      end else begin
         wr_sync <= {wr_sync[0], key_wr_n};
         rd_sync <= {rd_sync[0], key_rd_n};
      end
   end

   assign wr_s = wr_sync[1];
   assign rd_s = rd_sync[1];

   // Only the key that started the debounce matters; the other key is ignored
   // until the FSM is back in IDLE.
   assign pend_low = pend_rw ? !rd_s : !wr_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         counter   <= 20'd0;
         pend_rw   <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_rw    <= 1'b0;
         cmd_data  <= 8'd0;
         cmd_count <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               counter <= 20'd0;
               // Write has priority when both keys are down.
               if (!wr_s) begin
                  state   <= DEBOUNCE;
                  pend_rw <= 1'b0;
               end else if (!rd_s) begin
                  state   <= DEBOUNCE;
                  pend_rw <= 1'b1;
               end
            end
            DEBOUNCE: begin
               if (!pend_low) begin
                  state   <= IDLE;
                  counter <= 20'd0;
               end else if (counter == CNT_LAST) begin
                  state     <= ISSUE;
                  counter   <= 20'd0;
                  cmd_valid <= 1'b1;
                  cmd_rw    <= pend_rw;
                  cmd_data  <= {4'b0000, sw_data};
               end else begin
                  counter <= counter + 20'd1;
               end
            end
            ISSUE: begin
               if (cmd_ready) begin
                  state     <= RELEASE;
                  counter   <= 20'd0;
                  cmd_valid <= 1'b0;
                  cmd_count <= cmd_count + 8'd1;
               end
            end
            RELEASE: begin
               // Both keys must read high for DEBOUNCE_CNT consecutive cycles;
               // any bounce low restarts the count.
               if (!wr_s || !rd_s) begin
                  counter <= 20'd0;
               end else if (counter == CNT_LAST) begin
                  state   <= IDLE;
                  counter <= 20'd0;
               end else begin
                  counter <= counter + 20'd1;
               end
            end
            default: begin
               state   <= IDLE;
               counter <= 20'd0;
            end
         endcase
      end
   end

endmodule
